// File: rtl/blur_stream_packer_if.sv
// Stream bundle between the blur stage, the packer and the frame writer.
// The master modport is the packer's view: it takes the pixel strobe and
// m_ready, and drives the packed-word stream plus the overflow flag.
interface blur_stream_packer_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_user;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;

  modport master (
    input  pixel_in, pixel_valid, m_ready,
    output m_data, m_keep, m_last, m_user, m_valid, overflow
  );

  modport slave (
    output pixel_in, pixel_valid, m_ready,
    input  m_data, m_keep, m_last, m_user, m_valid, overflow
  );
endinterface

// File: rtl/blur_stream_packer.sv
// Packs the blur pixel stream four pixels per 32-bit word, tags end-of-row
// (m_last) and start-of-frame (m_user), and buffers words in a FIFO drained
// through a valid/ready port. Words arriving at a full FIFO are dropped and
// latch a sticky overflow flag; counters still advance so alignment holds.
module blur_stream_packer #(
  parameter int ROW_PIX = 254,
  parameter int ROWS    = 254,
  parameter int DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  blur_stream_packer_if.master bus_io
);

  localparam int CW = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int EW = 38;

  localparam logic [CW-1:0] COL_LAST = CW'(ROW_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);
  localparam logic [NW-1:0] CNT_ONE  = NW'(1);
  localparam logic [NW-1:0] CNT_ZERO = NW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Word assembly state
  logic [1:0]    idx_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [31:0]   word_q;
  logic [3:0]    keep_q;
  logic          user_pend_q;

  logic [31:0]   word_s;
  logic [3:0]    keep_s;
  logic          row_end_s;
  logic          push_s;
  logic [EW-1:0] push_word_s;

  // FIFO state; entry layout is {user, last, keep[3:0], data[31:0]}
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          pop_s, full_s, accept_s, drop_s;

  // Registered output head
  logic [EW-1:0] head_q, head_d;
  logic          m_valid_q;
  logic          ovf_q;

  assign row_end_s   = (col_q == COL_LAST);
  assign push_s      = bus_io.pixel_valid && ((idx_q == 2'd3) || row_end_s);
  assign push_word_s = {user_pend_q, row_end_s, keep_s, word_s};

  assign pop_s    = m_valid_q && bus_io.m_ready;
  assign full_s   = (cnt_q == CNT_FULL);
  assign accept_s = push_s && (!full_s || pop_s);
  assign drop_s   = push_s && full_s && !pop_s;

  // Merge the incoming pixel into the partial word at the current byte slot
  always_comb begin
    word_s = word_q;
    keep_s = keep_q;
    case (idx_q)
      2'd0: begin word_s[7:0]   = bus_io.pixel_in; keep_s[0] = 1'b1; end
      2'd1: begin word_s[15:8]  = bus_io.pixel_in; keep_s[1] = 1'b1; end
      2'd2: begin word_s[23:16] = bus_io.pixel_in; keep_s[2] = 1'b1; end
      2'd3: begin word_s[31:24] = bus_io.pixel_in; keep_s[3] = 1'b1; end
      default: begin word_s = word_q; keep_s = keep_q; end
    endcase
  end

  // FIFO pointer/count next state and the head word visible after this edge
  always_comb begin
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // A word pushed into an empty (or emptying) FIFO is not in memory yet,
    // so it is forwarded straight into the head register.
    if (cnt_d == CNT_ZERO) begin
      head_d = '0;
    end else if (accept_s && ((cnt_q == CNT_ZERO) || (pop_s && (cnt_q == CNT_ONE)))) begin
      head_d = push_word_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Advance byte index, column and row; hold the partial word between pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      word_q      <= 32'h0;
      keep_q      <= 4'h0;
      user_pend_q <= 1'b1;
    end else if (bus_io.pixel_valid) begin
      if (push_s) begin
        idx_q       <= 2'd0;
        word_q      <= 32'h0;
        keep_q      <= 4'h0;
        user_pend_q <= row_end_s && (row_q == ROW_LAST);
      end else begin
        idx_q       <= idx_q + 2'd1;
        word_q      <= word_s;
        keep_q      <= keep_s;
        user_pend_q <= user_pend_q;
      end
      if (row_end_s) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
        row_q <= row_q;
      end
    end else begin
      idx_q       <= idx_q;
      col_q       <= col_q;
      row_q       <= row_q;
      word_q      <= word_q;
      keep_q      <= keep_q;
      user_pend_q <= user_pend_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  // Registered stream outputs and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      m_valid_q <= (cnt_d != CNT_ZERO);
      ovf_q     <= ovf_q | drop_s;
    end
  end

  assign bus_io.m_data   = head_q[31:0];
  assign bus_io.m_keep   = head_q[35:32];
  assign bus_io.m_last   = head_q[36];
  assign bus_io.m_user   = head_q[37];
  assign bus_io.m_valid  = m_valid_q;
  assign bus_io.overflow = ovf_q;

endmodule

// File: doc/blur_stream_packer.md
# blur_stream_packer

Downstream stage of the 3x3 Gaussian blur. It consumes the blur output pixel stream, which has no backpressure and produces IMG_W-2 valid pixels per row once the window is primed. It packs four 8-bit pixels per 32-bit word, tags start-of-frame and end-of-row, and buffers the words in a FIFO. The FIFO drains through a valid/ready master port toward the frame writer / DMA. Words that cannot be buffered are dropped and flagged.

## Interface
Parameters:
- ROW_PIX, 254: valid pixels per row (IMG_W-2 of the blur stage); ≥1.
- ROWS, 254: valid rows per frame; ≥1.
- DEPTH, 16: FIFO depth in words; power of two, ≥2.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- pixel_in  in  8  blurred pixel (blur stage pixel_out).
- pixel_valid  in  1  pixel strobe (blur stage out_valid); no ready returned.
- m_data  out  32  packed word; byte k = k-th pixel of the word (first pixel in [7:0]).
- m_keep  out  4  byte enables; bit k set ⇔ byte k holds a real pixel.
- m_last  out  1  word is last of a row.
- m_user  out  1  word is first of a frame.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  downstream accepts head.
- overflow  out  1  sticky: a word was dropped since reset.

## Operation
- Pixel accepted on any clock edge with pixel_valid=1; gaps between pixels are allowed and have no effect.
- Assembly: a byte index 0..3, a column counter 0..ROW_PIX-1 and a row counter 0..ROWS-1, each $clog2-sized.
  - Each accepted pixel is written to byte[index], and its keep bit is set.
- A word is complete on the accepted pixel where index=3 or column=ROW_PIX-1.
  - On that edge the word is pushed with keep = bits set so far, unused bytes = 0x00.
  - m_last = (column=ROW_PIX-1).
  - m_user = 1 if it is the first word of row 0.
  - The index then returns to 0.
- Counter wrap:
  - column=ROW_PIX-1 → column 0, row+1.
  - row=ROWS-1 at row end → row 0; the next word carries m_user=1.
- FIFO: DEPTH entries × 38 bits (data, keep, last, user); count 0..DEPTH.
  - Push succeeds if count<DEPTH, or count=DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set to 1. Overflow stays 1 until rst.
  - Pop on an edge with m_valid=1 and m_ready=1.
  - Push and pop on the same edge: count unchanged, order preserved.
- A dropped word still advances the counters, so later words keep correct alignment and flags.
- Master rule: once m_valid=1, m_data/m_keep/m_last/m_user hold stable until a pop.
- rst (any time, including mid-word or mid-frame):
  - FIFO emptied; index, column and row cleared; the partial word is discarded.
  - overflow=0; the next word pushed carries m_user=1.

## Timing
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, m_user=0, overflow=0.
- Latency: a word pushed on edge E shows m_valid=1 in the cycle after E. There is no combinational path from pixel_valid to m_valid.
- m_ready has no combinational effect on any output other than the pop taking effect at the next edge. m_valid is not a function of m_ready.
- Empty FIFO: m_valid=0; payload outputs are don't-care (drive 0).
- Full FIFO: push allowed only with a simultaneous pop.
- Sustained throughput: 1 pixel/cycle in; at most 1 word per 4 pixels out. With m_ready held high the FIFO never exceeds 1 entry.
- Overflow rises in the cycle after the dropping edge.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → all outputs 0; after release with no pixels, m_valid stays 0.
- One row, defaults, m_ready=1, pixels 0..253:
  - 64 words total.
  - Word 0 = 0x03020100, keep=F, user=1, last=0.
  - Word 63 = 0x0000FDFC, keep=3, last=1.
  - overflow=0.
- Backpressure, DEPTH=16, m_ready=0, one 254-pixel row:
  - The first 16 words are stored; the 17th word drop sets overflow=1.
  - Then m_ready=1 → exactly 16 words drain in order, then m_valid=0.
  - overflow stays 1.
- Full with simultaneous pop, DEPTH=4:
  - Fill to 4, then push on the same edge as a pop → count stays 4, no drop, overflow=0.
  - Output order matches input order.
- Frame wrap, ROW_PIX=5, ROWS=2, two frames:
  - Per row: word with keep=F, then word with keep=1, last=1.
  - m_user=1 only on the first word of each frame (words 0 and 4).
- Reset mid-row: rst after 6 pixels of a row, then 5 fresh pixels 0xA0..0xA4 with ROW_PIX=5 → FIFO empty after reset; next words are 0xA3A2A1A0 with user=1, then 0x000000A4 with keep=1, last=1.
